uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning number of entries (power of two, 4..256).
REQ-002 SHALL have parameter CNT_W, default 5, meaning count width, equal to log2(DEPTH)+1.
REQ-003 SHALL have port clk  input  1  meaning system clock; all logic on rising edge.
REQ-004 SHALL have port rstN  input  1  meaning reset; synchronous and active-low.
REQ-005 SHALL have port rxDone  input  1  meaning byte-complete strobe from Uart8 receiver; level of any width.
REQ-006 SHALL have port rxErr  input  1  meaning frame-error flag from Uart8, sampled with rxDone.
REQ-007 SHALL have port rxByte  input  8  meaning received byte from Uart8 out.
REQ-008 SHALL have port rdEn  input  1  meaning consumer pop request.
REQ-009 SHALL have port clrOverflow  input  1  meaning clears sticky overflow flag.
REQ-010 SHALL have port rdData  output  8  meaning popped byte.
REQ-011 SHALL have port rdErr  output  1  meaning frame-error tag of popped byte.
REQ-012 SHALL have port rdValid  output  1  meaning one-cycle pulse: rdData/rdErr valid.
REQ-013 SHALL have port empty  output  1  meaning no entries stored.
REQ-014 SHALL have port full  output  1  meaning DEPTH entries stored.
REQ-015 SHALL have port count  output  CNT_W  meaning current occupancy.
REQ-016 SHALL have port overflow  output  1  meaning sticky: a byte was dropped.
REQ-017 SHALL have port errCount  output  8  meaning saturating count of stored entries tagged rxErr.

Function
REQ-018 SHALL register rxDone once and generate write request wr only on its 0->1 edge, so a held rxDone yields exactly one write.
REQ-019 SHALL store, on wr, a 9-bit entry {rxErr, rxByte} sampled in the same cycle as the detected edge.
REQ-020 SHALL accept pop request rd only when rdEn=1 and empty=0; rdEn while empty is ignored, no rdValid.
REQ-021 SHALL present the popped entry on rdData/rdErr and pulse rdValid exactly one cycle after the accepted rd; rdData/rdErr hold until the next accepted pop.
REQ-022 SHALL maintain circular write/read pointers of log2(DEPTH) bits wrapping DEPTH-1 -> 0.
REQ-023 SHALL update count: +1 on write only, -1 on read only, unchanged on both; empty = (count==0), full = (count==DEPTH), both combinational from count.
REQ-024 SHALL, on wr with full=1 and no accepted rd that cycle, drop the byte, leave pointers and count unchanged, and set overflow.
REQ-025 SHALL, on wr with full=1 and an accepted rd in the same cycle, perform both; count stays DEPTH, no overflow.
REQ-026 SHALL, on wr with empty=1 and rdEn=1 in the same cycle, store the byte, ignore the read, count becomes 1.
REQ-027 SHALL clear overflow on clrOverflow=1, except when a new drop occurs in the same cycle, where set wins.
REQ-028 SHALL increment errCount on each stored (not dropped) entry with rxErr=1, saturating at 255; it is cleared only by reset.

Reset
REQ-029 SHALL, while rstN=0 at a clock edge, set pointers, count and errCount to 0, overflow, rdValid, rdErr to 0, rdData to 8'h00, rxDone edge register to 0; empty=1, full=0.
REQ-030 SHALL discard stored entries on reset mid-operation; a rxDone held high across reset release is not counted as a new edge until it falls and rises again.
REQ-031 SHALL ignore rxDone and rdEn in any cycle where rstN=0.

Verification
REQ-032 SHALL verify: single rxDone pulse with rxByte=8'hD6, rxErr=0, then rdEn -> rdValid one cycle later, rdData=8'hD6, rdErr=0, empty returns to 1.
REQ-033 SHALL verify: rxDone held high 5 cycles with 8'hD6 -> count=1, not 5.
REQ-034 SHALL verify: 17 writes 8'h00..8'h10 with DEPTH=16, no reads -> full=1, overflow=1, 16 pops return 8'h00..8'h0F in order, 8'h10 absent; clrOverflow then clears flag.
REQ-035 SHALL verify: full FIFO, write 8'hA5 and rdEn in the same cycle -> count stays 16, overflow=0, last pop returns 8'hA5.
REQ-036 SHALL verify: write 8'h3C with rxErr=1 -> errCount=1, pop gives rdErr=1; 300 such writes with interleaved reads -> errCount=255.
REQ-037 SHALL verify: 3 bytes stored, rstN=0 one cycle -> count=0, empty=1, rdEn yields no rdValid.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind a UART byte receiver: edge-detects the receiver's
// done strobe, stores {frame_error, byte} entries, and pops them on request
// with a one-cycle valid pulse. Tracks a sticky overflow flag and a
// saturating count of error-tagged entries.
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             rxDone,
  input  logic             rxErr,
  input  logic [7:0]       rxByte,
  input  logic             rdEn,
  input  logic             clrOverflow,
  output logic [7:0]       rdData,
  output logic             rdErr,
  output logic             rdValid,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic [7:0]       errCount
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned ENT_W = 9;

  logic             rx_done_q, rx_done_d;
  logic             rx_arm_q, rx_arm_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic [7:0]       rd_data_q, rd_data_d;
  logic             rd_err_q, rd_err_d;
  logic             rd_valid_q, rd_valid_d;

  logic             wr_c, rd_c, push_c, drop_c, empty_c, full_c;
  logic [ENT_W-1:0] rd_ent_c;
  logic [ENT_W-1:0] mem_q [DEPTH];

  // Next-state: edge detect, push/pop arbitration, occupancy and flags
  always_comb begin
    rx_done_d  = rxDone;
    rx_arm_d   = rx_arm_q | ~rxDone;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    err_cnt_d  = err_cnt_q;
    rd_data_d  = rd_data_q;
    rd_err_d   = rd_err_q;
    rd_valid_d = 1'b0;

    empty_c  = (count_q == '0);
    full_c   = (count_q == CNT_W'(DEPTH));
    // rx_arm_q suppresses a strobe that was already high when reset released
    wr_c     = rxDone & ~rx_done_q & rx_arm_q;
    rd_c     = rdEn & ~empty_c;
    push_c   = wr_c & (~full_c | rd_c);
    drop_c   = wr_c & full_c & ~rd_c;
    rd_ent_c = mem_q[rd_ptr_q];

    if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_c)   rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push_c, rd_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (drop_c)           overflow_d = 1'b1;
    else if (clrOverflow) overflow_d = 1'b0;

    if (push_c && rxErr && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;

    if (rd_c) begin
      rd_valid_d = 1'b1;
      rd_data_d  = rd_ent_c[7:0];
      rd_err_d   = rd_ent_c[8];
    end
  end

  // Control/status registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstN) begin
      rx_done_q  <= 1'b0;
      rx_arm_q   <= ~rxDone;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      err_cnt_q  <= 8'h00;
      rd_data_q  <= 8'h00;
      rd_err_q   <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      rx_done_q  <= rx_done_d;
      rx_arm_q   <= rx_arm_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      err_cnt_q  <= err_cnt_d;
      rd_data_q  <= rd_data_d;
      rd_err_q   <= rd_err_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Entry storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (rstN && push_c) mem_q[wr_ptr_q] <= {rxErr, rxByte};
  end

  assign rdData   = rd_data_q;
  assign rdErr    = rd_err_q;
  assign rdValid  = rd_valid_q;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign errCount = err_cnt_q;
  assign empty    = empty_c;
  assign full     = full_c;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a queue scoreboard fed from the
// driven stimulus, compared every cycle against rdValid/rdData/status.
module tb_uart_rx_fifo;

  localparam int unsigned DEPTH   = 16;
  localparam int unsigned CNT_W   = 5;
  localparam int          DEPTH_I = 16;

  logic             clk = 1'b0;
  logic             rstN, rxDone, rxErr, rdEn, clrOverflow;
  logic [7:0]       rxByte;
  logic [7:0]       rdData;
  logic             rdErr, rdValid, empty, full, overflow;
  logic [CNT_W-1:0] count;
  logic [7:0]       errCount;

  int errors = 0;
  int checks = 0;

  // Scoreboard and reference state
  logic [8:0] sb[$];
  logic [8:0] m_last = 9'h000;
  logic       m_ovf  = 1'b0;
  int         m_err  = 0;
  logic       m_prev = 1'b0;
  logic       m_arm  = 1'b0;

  uart_rx_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstN(rstN), .rxDone(rxDone), .rxErr(rxErr), .rxByte(rxByte),
    .rdEn(rdEn), .clrOverflow(clrOverflow), .rdData(rdData), .rdErr(rdErr),
    .rdValid(rdValid), .empty(empty), .full(full), .count(count),
    .overflow(overflow), .errCount(errCount)
  );

  always #5 clk = ~clk;

  // Advance one clock: update the reference from the inputs presented this
  // cycle, then compare the DUT outputs 1ns after the edge.
  task automatic tick();
    logic rd_ok, wr_ok, full_m, drop;
    rd_ok = 1'b0; wr_ok = 1'b0; full_m = 1'b0; drop = 1'b0;
    if (!rstN) begin
      sb.delete();
      m_ovf = 1'b0; m_err = 0; m_last = 9'h000; m_prev = 1'b0; m_arm = !rxDone;
    end else begin
      rd_ok  = rdEn && (sb.size() != 0);
      wr_ok  = rxDone && !m_prev && m_arm;
      full_m = (sb.size() == DEPTH_I);
      drop   = wr_ok && full_m && !rd_ok;
      if (rd_ok) m_last = sb.pop_front();
      if (wr_ok && !drop) begin
        sb.push_back({rxErr, rxByte});
        if (rxErr && m_err < 255) m_err++;
      end
      if (drop) m_ovf = 1'b1;
      else if (clrOverflow) m_ovf = 1'b0;
      m_arm  = m_arm || !rxDone;
      m_prev = rxDone;
    end
    @(posedge clk); #1;
    checks++;
    if (rdValid !== rd_ok || {rdErr, rdData} !== m_last) begin
      errors++;
      $display("FAIL pop_out t=%0t: rdValid=%b err=%b data=%h, required rdValid=%b err=%b data=%h",
               $time, rdValid, rdErr, rdData, rd_ok, m_last[8], m_last[7:0]);
    end
    checks++;
    if (count !== CNT_W'(sb.size()) || empty !== (sb.size() == 0) ||
        full !== (sb.size() == DEPTH_I) || overflow !== m_ovf || errCount !== 8'(m_err)) begin
      errors++;
      $display("FAIL status t=%0t: count=%0d empty=%b full=%b ovf=%b errCount=%0d, required %0d %b %b %b %0d",
               $time, count, empty, full, overflow, errCount, sb.size(), sb.size() == 0,
               sb.size() == DEPTH_I, m_ovf, m_err);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic e);
    rxByte = b; rxErr = e; rxDone = 1'b1;
    tick();
    rxDone = 1'b0;
    tick();
  endtask

  task automatic pop();
    rdEn = 1'b1;
    tick();
    rdEn = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    repeat (2) tick();
    rstN = 1'b1;
    checks++;
    if (empty !== 1'b1 || full !== 1'b0 || count !== CNT_W'(0) || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: empty=%b full=%b count=%0d ovf=%b, required 1 0 0 0",
               empty, full, count, overflow);
    end
    checks++;
    if (rdValid !== 1'b0 || rdData !== 8'h00 || rdErr !== 1'b0 || errCount !== 8'h00) begin
      errors++;
      $display("FAIL reset_out: rdValid=%b rdData=%h rdErr=%b errCount=%0d, required 0 00 0 0",
               rdValid, rdData, rdErr, errCount);
    end
  endtask

  task automatic test_single();
    send(8'hD6, 1'b0);
    checks++;
    if (count !== CNT_W'(1) || empty !== 1'b0) begin
      errors++;
      $display("FAIL single_store: count=%0d empty=%b, required 1 0", count, empty);
    end
    rdEn = 1'b1;
    tick();
    rdEn = 1'b0;
    checks++;
    if (rdValid !== 1'b1 || rdData !== 8'hD6 || rdErr !== 1'b0) begin
      errors++;
      $display("FAIL single_pop: rdValid=%b rdData=%h rdErr=%b, required 1 d6 0", rdValid, rdData, rdErr);
    end
    tick();
    checks++;
    if (empty !== 1'b1 || rdValid !== 1'b0) begin
      errors++;
      $display("FAIL single_empty: empty=%b rdValid=%b, required 1 0", empty, rdValid);
    end
  endtask

  task automatic test_held();
    rxByte = 8'hD6; rxErr = 1'b0; rxDone = 1'b1;
    repeat (5) tick();
    rxDone = 1'b0;
    tick();
    checks++;
    if (count !== CNT_W'(1)) begin
      errors++;
      $display("FAIL held_strobe: count=%0d, required 1", count);
    end
    pop();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 17; i++) send(8'(i), 1'b0);
    checks++;
    if (full !== 1'b1 || overflow !== 1'b1 || count !== CNT_W'(16)) begin
      errors++;
      $display("FAIL ovf_fill: full=%b ovf=%b count=%0d, required 1 1 16", full, overflow, count);
    end
    for (int i = 0; i < 16; i++) begin
      rdEn = 1'b1;
      tick();
      rdEn = 1'b0;
      checks++;
      if (rdValid !== 1'b1 || rdData !== 8'(i)) begin
        errors++;
        $display("FAIL ovf_order[%0d]: rdValid=%b rdData=%h, required 1 %h", i, rdValid, rdData, 8'(i));
      end
      tick();
    end
    rdEn = 1'b1;
    tick();
    rdEn = 1'b0;
    checks++;
    if (rdValid !== 1'b0 || rdData !== 8'h0F || empty !== 1'b1) begin
      errors++;
      $display("FAIL ovf_dropped: rdValid=%b rdData=%h empty=%b, required 0 0f 1", rdValid, rdData, empty);
    end
    clrOverflow = 1'b1;
    tick();
    clrOverflow = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: overflow=%b, required 0", overflow);
    end
  endtask

  task automatic test_full_rw();
    logic [7:0] last;
    for (int i = 0; i < 16; i++) send(8'h40 + 8'(i), 1'b0);
    rxByte = 8'hA5; rxErr = 1'b0; rxDone = 1'b1; rdEn = 1'b1;
    tick();
    rxDone = 1'b0; rdEn = 1'b0;
    checks++;
    if (count !== CNT_W'(16) || overflow !== 1'b0 || rdValid !== 1'b1 || rdData !== 8'h40) begin
      errors++;
      $display("FAIL full_rw: count=%0d ovf=%b rdValid=%b rdData=%h, required 16 0 1 40",
               count, overflow, rdValid, rdData);
    end
    tick();
    last = 8'h00;
    for (int i = 0; i < 16; i++) begin
      rdEn = 1'b1;
      tick();
      rdEn = 1'b0;
      last = rdData;
      tick();
    end
    checks++;
    if (last !== 8'hA5) begin
      errors++;
      $display("FAIL full_rw_last: rdData=%h, required a5", last);
    end
  endtask

  task automatic test_empty_rw();
    rxByte = 8'h7E; rxErr = 1'b0; rxDone = 1'b1; rdEn = 1'b1;
    tick();
    rxDone = 1'b0; rdEn = 1'b0;
    checks++;
    if (count !== CNT_W'(1) || rdValid !== 1'b0) begin
      errors++;
      $display("FAIL empty_rw: count=%0d rdValid=%b, required 1 0", count, rdValid);
    end
    tick();
    pop();
  endtask

  task automatic test_clr_vs_drop();
    for (int i = 0; i < 16; i++) send(8'h60 + 8'(i), 1'b0);
    rxByte = 8'hEE; rxErr = 1'b0; rxDone = 1'b1; clrOverflow = 1'b1;
    tick();
    rxDone = 1'b0; clrOverflow = 1'b0;
    checks++;
    if (overflow !== 1'b1 || count !== CNT_W'(16)) begin
      errors++;
      $display("FAIL drop_beats_clear: ovf=%b count=%0d, required 1 16", overflow, count);
    end
    tick();
    clrOverflow = 1'b1;
    tick();
    clrOverflow = 1'b0;
    for (int i = 0; i < 16; i++) pop();
  endtask

  task automatic test_err();
    send(8'h3C, 1'b1);
    checks++;
    if (errCount !== 8'd1) begin
      errors++;
      $display("FAIL err_first: errCount=%0d, required 1", errCount);
    end
    rdEn = 1'b1;
    tick();
    rdEn = 1'b0;
    checks++;
    if (rdValid !== 1'b1 || rdErr !== 1'b1 || rdData !== 8'h3C) begin
      errors++;
      $display("FAIL err_tag: rdValid=%b rdErr=%b rdData=%h, required 1 1 3c", rdValid, rdErr, rdData);
    end
    tick();
    repeat (300) begin
      send(8'h3C, 1'b1);
      pop();
    end
    checks++;
    if (errCount !== 8'd255) begin
      errors++;
      $display("FAIL err_saturate: errCount=%0d, required 255", errCount);
    end
  endtask

  task automatic test_reset_mid();
    send(8'h01, 1'b1); send(8'h02, 1'b0); send(8'h03, 1'b0);
    checks++;
    if (count !== CNT_W'(3)) begin
      errors++;
      $display("FAIL mid_fill: count=%0d, required 3", count);
    end
    rstN = 1'b0;
    tick();
    rstN = 1'b1;
    checks++;
    if (count !== CNT_W'(0) || empty !== 1'b1 || errCount !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset: count=%0d empty=%b errCount=%0d, required 0 1 0", count, empty, errCount);
    end
    rdEn = 1'b1;
    tick();
    rdEn = 1'b0;
    checks++;
    if (rdValid !== 1'b0) begin
      errors++;
      $display("FAIL mid_no_pop: rdValid=%b, required 0", rdValid);
    end
    tick();
  endtask

  task automatic test_held_reset();
    rxByte = 8'h11; rxErr = 1'b0; rxDone = 1'b1; rstN = 1'b0;
    tick();
    rstN = 1'b1;
    repeat (3) tick();
    checks++;
    if (count !== CNT_W'(0)) begin
      errors++;
      $display("FAIL held_over_reset: count=%0d, required 0", count);
    end
    rxDone = 1'b0;
    tick();
    rxByte = 8'h22; rxDone = 1'b1;
    tick();
    rxDone = 1'b0;
    checks++;
    if (count !== CNT_W'(1)) begin
      errors++;
      $display("FAIL rearm_edge: count=%0d, required 1", count);
    end
    tick();
    rdEn = 1'b1;
    tick();
    rdEn = 1'b0;
    checks++;
    if (rdValid !== 1'b1 || rdData !== 8'h22) begin
      errors++;
      $display("FAIL rearm_data: rdValid=%b rdData=%h, required 1 22", rdValid, rdData);
    end
    tick();
  endtask

  initial begin
    rstN = 1'b0; rxDone = 1'b0; rxErr = 1'b0; rxByte = 8'h00;
    rdEn = 1'b0; clrOverflow = 1'b0;
    test_reset();
    test_single();
    test_held();
    test_overflow();
    test_full_rw();
    test_empty_rw();
    test_clr_vs_drop();
    test_err();
    test_reset_mid();
    test_held_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
